// File: rtl/level_object_placer.sv
// Collects one random grid tile per level on successive Enter presses, then
// presents the pixel position and bitmap index of the selected level.
module level_object_placer #(
    parameter int NUM_LEVELS = 4,
    parameter int COORD_W    = 11,
    parameter int RAND_W     = 5,
    parameter int TILE_SHIFT = 6,
    parameter int X_OFFSET   = 15,
    parameter int Y_OFFSET   = 48,
    parameter int GRID_COLS  = 10,
    parameter int GRID_ROWS  = 7,
    parameter int LVL_W      = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_enter_pressed,
    input  logic [LVL_W-1:0]   i_level_select,
    input  logic [RAND_W-1:0]  i_random_num1,
    input  logic [RAND_W-1:0]  i_random_num2,
    input  logic               i_game_on,
    output logic [COORD_W-1:0] o_topLeftX,
    output logic [COORD_W-1:0] o_topLeftY,
    output logic [LVL_W-1:0]   o_bitmap_sel,
    output logic               o_coords_valid,
    output logic               o_busy,
    output logic               o_reject_pulse,
    output logic [LVL_W:0]     o_slots_filled
);

    typedef enum logic [1:0] {
        IDLE_ST    = 2'd0,
        COLLECT_ST = 2'd1,
        READY_ST   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_enter_d;
    logic [RAND_W-1:0]   r_slot_col [NUM_LEVELS];
    logic [RAND_W-1:0]   r_slot_row [NUM_LEVELS];
    logic [COORD_W-1:0]  r_top_left_x;
    logic [COORD_W-1:0]  r_top_left_y;
    logic [LVL_W-1:0]    r_bitmap_sel;
    logic                r_coords_valid;
    logic                r_busy;
    logic                r_reject_pulse;
    logic [LVL_W:0]      r_slots_filled;

    logic                w_enter_rise;
    logic                w_out_of_grid;
    logic                w_player_start;
    logic                w_dup;
    logic                w_reject;
    logic                w_sel_ok;

    function automatic logic [COORD_W-1:0] tile_to_px(input logic [RAND_W-1:0] tile,
                                                      input int offset);
        return (COORD_W'(tile) << TILE_SHIFT) + COORD_W'(offset);
    endfunction

    assign w_enter_rise   = i_enter_pressed & ~r_enter_d;
    assign w_out_of_grid  = (32'(i_random_num1) >= GRID_COLS) || (32'(i_random_num2) >= GRID_ROWS);
    assign w_player_start = (i_random_num1 == {RAND_W{1'b0}}) && (i_random_num2 == {RAND_W{1'b0}});
    assign w_reject       = w_out_of_grid | w_player_start | w_dup;
    assign w_sel_ok       = 32'(i_level_select) < NUM_LEVELS;

    // Only slots below the fill count are live; older entries are stale after a restart.
    always_comb begin
        w_dup = 1'b0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            w_dup = w_dup | ((k < 32'(r_slots_filled)) &&
                             (r_slot_col[k] == i_random_num1) &&
                             (r_slot_row[k] == i_random_num2));
        end
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= IDLE_ST;
            r_enter_d      <= 1'b0;
            r_top_left_x   <= {COORD_W{1'b0}};
            r_top_left_y   <= {COORD_W{1'b0}};
            r_bitmap_sel   <= {LVL_W{1'b0}};
            r_coords_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_reject_pulse <= 1'b0;
            r_slots_filled <= {(LVL_W+1){1'b0}};
            for (int k = 0; k < NUM_LEVELS; k++) begin
                r_slot_col[k] <= {RAND_W{1'b0}};
                r_slot_row[k] <= {RAND_W{1'b0}};
            end
        end else begin
            r_enter_d      <= i_enter_pressed;
            r_reject_pulse <= 1'b0;
            case (r_state)
                IDLE_ST: begin
                    if (w_enter_rise) begin
                        r_state        <= COLLECT_ST;
                        r_slots_filled <= {(LVL_W+1){1'b0}};
                        r_busy         <= 1'b1;
                    end else begin
                        r_state <= IDLE_ST;
                    end
                end
                COLLECT_ST: begin
                    if (w_enter_rise && w_reject) begin
                        r_reject_pulse <= 1'b1;
                    end else if (w_enter_rise) begin
                        r_slot_col[r_slots_filled[LVL_W-1:0]] <= i_random_num1;
                        r_slot_row[r_slots_filled[LVL_W-1:0]] <= i_random_num2;
                        r_slots_filled <= r_slots_filled + (LVL_W+1)'(1);
                        if (r_slots_filled == (LVL_W+1)'(NUM_LEVELS - 1)) begin
                            r_state <= READY_ST;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= COLLECT_ST;
                        end
                    end else begin
                        r_state <= COLLECT_ST;
                    end
                end
                READY_ST: begin
                    if (w_enter_rise && !i_game_on) begin
                        r_state        <= IDLE_ST;
                        r_coords_valid <= 1'b0;
                        r_slots_filled <= {(LVL_W+1){1'b0}};
                    end else if (w_sel_ok) begin
                        r_top_left_x   <= tile_to_px(r_slot_col[i_level_select], X_OFFSET);
                        r_top_left_y   <= tile_to_px(r_slot_row[i_level_select], Y_OFFSET);
                        r_bitmap_sel   <= i_level_select;
                        r_coords_valid <= 1'b1;
                    end else begin
                        r_coords_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE_ST;
                end
            endcase
        end
    end

    assign o_topLeftX     = r_top_left_x;
    assign o_topLeftY     = r_top_left_y;
    assign o_bitmap_sel   = r_bitmap_sel;
    assign o_coords_valid = r_coords_valid;
    assign o_busy         = r_busy;
    assign o_reject_pulse = r_reject_pulse;
    assign o_slots_filled = r_slots_filled;

endmodule

// File: tb/tb_level_object_placer.sv
// Bench for level_object_placer: a 4-level and a 3-level instance share stimulus
// and are each checked every cycle against a queue-based behavioural model.
module tb_level_object_placer;

    localparam int NI = 2;
    int n_lv [NI] = '{4, 3};

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       enter = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [4:0] rn1 = 5'd0;
    logic [4:0] rn2 = 5'd0;
    logic       game_on = 1'b0;

    logic [10:0] x_o     [NI];
    logic [10:0] y_o     [NI];
    logic [1:0]  sel_o   [NI];
    logic        valid_o [NI];
    logic        busy_o  [NI];
    logic        rej_o   [NI];
    logic [2:0]  fill_o  [NI];

    int n_cmp = 0;
    int n_fail = 0;

    // behavioural model: mode 0=idle 1=collect 2=ready, stored tiles as queues
    int m_mode [NI];
    int q_col [NI][$];
    int q_row [NI][$];
    bit m_prev;
    int e_x [NI], e_y [NI], e_sel [NI], e_valid [NI], e_busy [NI], e_rej [NI], e_fill [NI];

    always #5 clk = ~clk;

    level_object_placer #(.NUM_LEVELS(4)) u_dut4 (
        .clk(clk), .resetN(resetN), .i_enter_pressed(enter), .i_level_select(sel),
        .i_random_num1(rn1), .i_random_num2(rn2), .i_game_on(game_on),
        .o_topLeftX(x_o[0]), .o_topLeftY(y_o[0]), .o_bitmap_sel(sel_o[0]),
        .o_coords_valid(valid_o[0]), .o_busy(busy_o[0]), .o_reject_pulse(rej_o[0]),
        .o_slots_filled(fill_o[0]));

    level_object_placer #(.NUM_LEVELS(3)) u_dut3 (
        .clk(clk), .resetN(resetN), .i_enter_pressed(enter), .i_level_select(sel),
        .i_random_num1(rn1), .i_random_num2(rn2), .i_game_on(game_on),
        .o_topLeftX(x_o[1]), .o_topLeftY(y_o[1]), .o_bitmap_sel(sel_o[1]),
        .o_coords_valid(valid_o[1]), .o_busy(busy_o[1]), .o_reject_pulse(rej_o[1]),
        .o_slots_filled(fill_o[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("x[%0d]", i), 32'(x_o[i]), e_x[i]);
            chk($sformatf("y[%0d]", i), 32'(y_o[i]), e_y[i]);
            chk($sformatf("bitmap_sel[%0d]", i), 32'(sel_o[i]), e_sel[i]);
            chk($sformatf("coords_valid[%0d]", i), 32'(valid_o[i]), e_valid[i]);
            chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), e_busy[i]);
            chk($sformatf("reject_pulse[%0d]", i), 32'(rej_o[i]), e_rej[i]);
            chk($sformatf("slots_filled[%0d]", i), 32'(fill_o[i]), e_fill[i]);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_mode[i] = 0;
            q_col[i].delete();
            q_row[i].delete();
            e_x[i] = 0; e_y[i] = 0; e_sel[i] = 0; e_valid[i] = 0;
            e_busy[i] = 0; e_rej[i] = 0; e_fill[i] = 0;
        end
    endtask

    // advance one clock: predict from current inputs, then compare after the edge
    task automatic step();
        bit rise;
        bit bad;
        int c, r, s;
        rise = enter && !m_prev;
        c = int'(rn1);
        r = int'(rn2);
        s = int'(sel);
        for (int i = 0; i < NI; i++) begin
            e_rej[i] = 0;
            if (m_mode[i] == 0) begin
                if (rise) begin
                    m_mode[i] = 1;
                    q_col[i].delete();
                    q_row[i].delete();
                    e_fill[i] = 0;
                    e_busy[i] = 1;
                end
            end else if (m_mode[i] == 1) begin
                if (rise) begin
                    bad = (c >= 10) || (r >= 7) || (c == 0 && r == 0);
                    foreach (q_col[i][k]) if (q_col[i][k] == c && q_row[i][k] == r) bad = 1'b1;
                    if (bad) e_rej[i] = 1;
                    else begin
                        q_col[i].push_back(c);
                        q_row[i].push_back(r);
                        e_fill[i] = q_col[i].size();
                        if (q_col[i].size() == n_lv[i]) begin
                            m_mode[i] = 2;
                            e_busy[i] = 0;
                        end
                    end
                end
            end else begin
                if (rise && !game_on) begin
                    m_mode[i] = 0;
                    e_valid[i] = 0;
                    e_fill[i] = 0;
                end else if (s < n_lv[i]) begin
                    e_x[i] = (q_col[i][s] * 64 + 15) % 2048;
                    e_y[i] = (q_row[i][s] * 64 + 48) % 2048;
                    e_sel[i] = s;
                    e_valid[i] = 1;
                end else begin
                    e_valid[i] = 0;
                end
            end
        end
        m_prev = enter;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic press(input int c, input int r);
        rn1 = 5'(c);
        rn2 = 5'(r);
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        resetN = 1'b1;
        step();

        game_on = 1'b1;
        press(0, 0);
        press(3, 2);
        chk("fill_after_3_2", 32'(fill_o[0]), 32'd1);
        press(3, 2);
        press(0, 0);
        press(12, 1);
        press(2, 9);
        chk("fill_after_rejects", 32'(fill_o[0]), 32'd1);
        chk("busy_after_rejects", 32'(busy_o[0]), 32'd1);

        rn1 = 5'd5;
        rn2 = 5'd1;
        enter = 1'b1;
        repeat (50) step();
        enter = 1'b0;
        step();
        chk("fill_after_hold", 32'(fill_o[0]), 32'd2);

        press(0, 4);
        press(9, 6);
        chk("fill_full", 32'(fill_o[0]), 32'd4);

        sel = 2'd1;
        step();
        chk("x_sel1", 32'(x_o[0]), 32'd335);
        chk("y_sel1", 32'(y_o[0]), 32'd112);
        sel = 2'd3;
        step();
        chk("x_sel3", 32'(x_o[0]), 32'd591);
        chk("y_sel3", 32'(y_o[0]), 32'd432);
        chk("valid_sel3_n3", 32'(valid_o[1]), 32'd0);
        sel = 2'd2;
        step();
        chk("x_sel2", 32'(x_o[0]), 32'd15);
        chk("y_sel2", 32'(y_o[0]), 32'd304);

        press(1, 1);
        chk("valid_game_on", 32'(valid_o[0]), 32'd1);
        game_on = 1'b0;
        press(1, 1);
        chk("valid_restart", 32'(valid_o[0]), 32'd0);
        game_on = 1'b1;
        press(0, 0);
        press(3, 2);
        press(5, 1);

        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        resetN = 1'b1;
        step();
        press(0, 0);
        press(3, 2);
        chk("fill_after_reset_3_2", 32'(fill_o[0]), 32'd1);

        for (int n = 0; n < 600; n++) begin
            enter   = ($urandom_range(0, 2) == 0);
            rn1     = 5'($urandom_range(0, 12));
            rn2     = 5'($urandom_range(0, 9));
            sel     = 2'($urandom_range(0, 3));
            game_on = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/level_object_placer.md
Name: level_object_placer

Overview:
- Parametrised successor to the door/idol placement controller.
- Collects one random tile position per level (NUM_LEVELS slots) on successive Enter presses.
- Rejects positions that are out of the grid, on the reserved player-start tile, or duplicate an already-stored slot.
- Once every slot is filled, drives the pixel coordinates and bitmap index of the currently selected level to the object drawer.

Parameters:
NUM_LEVELS, 4, number of level slots collected (>=2)
COORD_W, 11, width of pixel coordinate outputs
RAND_W, 5, width of each random input
TILE_SHIFT, 6, log2 of tile size in pixels (64)
X_OFFSET, 15, pixel offset added to X
Y_OFFSET, 48, pixel offset added to Y
GRID_COLS, 10, valid column range 0..GRID_COLS-1
GRID_ROWS, 7, valid row range 0..GRID_ROWS-1
LVL_W, max(1,$clog2(NUM_LEVELS)), derived: level index width

Ports:
clk  in  1  system clock
resetN  in  1  reset
enter_pressed  in  1  Enter key level, synchronous to clk
level_select  in  LVL_W  active level index, 0-based
random_num1  in  RAND_W  candidate column
random_num2  in  RAND_W  candidate row
game_on  in  1  gameplay active; blocks restart
topLeftX  out  COORD_W  object X of selected level
topLeftY  out  COORD_W  object Y of selected level
bitmap_sel  out  LVL_W  bitmap index (= selected level)
coords_valid  out  1  outputs meaningful
busy  out  1  high in COLLECT_ST
reject_pulse  out  1  one-cycle pulse on rejected candidate
slots_filled  out  LVL_W+1  number of accepted slots

Behaviour:
- Interface: reset resetN, asynchronous, active-low; clock clk.
- All outputs are registered. Reset values:
  - topLeftX, topLeftY, bitmap_sel, slots_filled = 0.
  - coords_valid, busy, reject_pulse = 0.
  - State = IDLE_ST; enter_d = 0; stored slot tiles cleared.
- Edge detect: enter_rise = enter_pressed & ~enter_d, with enter_d registered every cycle. A held key produces exactly one rise.
- IDLE_ST: on enter_rise -> COLLECT_ST; slots_filled <= 0; busy <= 1.
- COLLECT_ST: on enter_rise, sample col = random_num1, row = random_num2. Reject if any of:
  - col >= GRID_COLS or row >= GRID_ROWS;
  - (col,row) == (0,0), the player-start tile;
  - (col,row) equals any stored slot k < slots_filled.
- On reject: reject_pulse = 1 for exactly the next cycle; state and slots unchanged.
- On accept: store (col,row) in slot[slots_filled]; slots_filled increments.
- When the increment reaches NUM_LEVELS -> READY_ST and busy <= 0, registered together with the last store.
- Coordinate math (zero-extended, truncated to COORD_W, no saturation):
  - X = (col << TILE_SHIFT) + X_OFFSET
  - Y = (row << TILE_SHIFT) + Y_OFFSET
  - Computed from the stored tile in READY_ST.
- READY_ST, every cycle:
  - If level_select < NUM_LEVELS: topLeftX/Y <= coords of slot[level_select]; bitmap_sel <= level_select; coords_valid <= 1.
  - Otherwise: topLeftX/Y and bitmap_sel hold their last values; coords_valid <= 0.
  - Latency: 1 cycle from a level_select change to the new outputs.
- Leaving READY_ST: enter_rise with game_on = 0 -> IDLE_ST; coords_valid <= 0; slots_filled <= 0. topLeftX/Y hold their values. enter_rise with game_on = 1 is ignored.
- Stored slot tiles are not cleared on restart; only slots_filled resets, which invalidates old entries for duplicate checks.
- The edge that causes a state transition is consumed; it does not also act in the new state.
- Asserting resetN mid-collection returns immediately to the reset values; partially collected slots are discarded.

Test Plan:
- Reset, then rise, then rises with (3,2),(5,1),(0,4),(9,6) -> slots_filled 1..4, then READY_ST. level_select=1 -> one cycle later topLeftX=335, topLeftY=112, bitmap_sel=1, coords_valid=1.
- In COLLECT_ST after (3,2) accepted: rise with (3,2), then (0,0), then (12,1), then (2,9) -> reject_pulse 1 cycle each; slots_filled stays 1; busy=1.
- Hold enter_pressed high for 50 cycles in COLLECT_ST with valid randoms -> exactly one slot accepted.
- READY_ST, level_select=3 then 2, checking the edges: (9,6) -> X=591, Y=432; (0,4) -> X=15, Y=304. Each update appears 1 cycle after level_select changes. With NUM_LEVELS=3 and level_select=3 -> coords_valid=0 and X/Y held.
- READY_ST, game_on=1, rise -> state unchanged. game_on=0, rise -> IDLE_ST, coords_valid=0, slots_filled=0; the next rise enters COLLECT_ST.
- Drop resetN after 2 accepted slots -> all outputs 0 asynchronously. After release, the first rise enters COLLECT_ST with slots_filled=0, and a previously stored tile such as (3,2) is accepted.
